multicycle_ctrl: RTL and testbench

- Multi-cycle control unit upstream of the 11-instruction data path.
- Takes the 4-bit opcode the data path decodes and produces the per-cycle control that sequences each instruction:
  - ALU/accumulator selects
  - instruction-register load
  - PC advance/load
  - register-file write
  - data-RAM read/write strobes
- Handshakes with the instruction ROM (instr_valid) and the data RAM (mem_ready), so slow memories stall the core instead of corrupting it.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_decode.sv | 56 +++++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, state and control-code definitions for the multi-cycle controller.
package ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_BAN  = 4'd10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_MEM    = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_NONE   = 2'd3
    } op_class_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SHIFT = 3'b100;
    localparam logic [2:0] ALU_NONE  = 3'b111;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_SHL  = 2'b01;
    localparam logic [1:0] ACC_SHR  = 2'b10;

    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_BAN);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ALU/accumulator selects, instruction class and legality.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [2:0]       alu_ctl,
    output logic [1:0]       acc_ctl,
    output op_class_t        op_class,
    output logic             legal
);

    logic [3:0] op4;
    logic       upper_zero;

    // Any set bit above the 4-bit opcode field makes the instruction undefined.
    assign op4        = opcode[3:0];
    assign upper_zero = ((opcode >> 4) == '0);

    always_comb begin
        alu_ctl  = ALU_NONE;
        acc_ctl  = ACC_NONE;
        legal    = 1'b0;
        op_class = CLS_NONE;
        case (op4)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_ctl = ALU_ADD;
            OP_SUB, OP_BAN:                alu_ctl = ALU_SUB;
            OP_AND:                        alu_ctl = ALU_AND;
            OP_OR:                         alu_ctl = ALU_OR;
            OP_SHL: begin
                alu_ctl = ALU_SHIFT;
                acc_ctl = ACC_SHL;
            end
            OP_SHR: begin
                alu_ctl = ALU_SHIFT;
                acc_ctl = ACC_SHR;
            end
            default: ;
        endcase
        if (!upper_zero) begin
            alu_ctl = ALU_NONE;
            acc_ctl = ACC_NONE;
        end
        legal = upper_zero && (is_alu(op4) || is_mem(op4) || is_branch(op4));
        if (legal) begin
            if (is_alu(op4))
                op_class = CLS_ALU;
            else if (is_mem(op4))
                op_class = CLS_MEM;
            else
                op_class = CLS_BRANCH;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 11-instruction data path, with ROM/RAM stall handshakes.
// Define MEM_TIMEOUT_EN to add a watchdog that abandons MEM accesses that never complete.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPC_W          = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             instr_valid,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic [2:0]       alu_ctl,
    output logic [1:0]       acc_ctl,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire, set_illegal, mem_timeout;

    logic [2:0]       dec_alu;
    logic [1:0]       dec_acc;
    op_class_t        dec_class;
    logic             dec_legal;
    logic             is_lw, is_jmp;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 4-bit MEM wait counter");
    end

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode   (opcode),
        .alu_ctl  (dec_alu),
        .acc_ctl  (dec_acc),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign is_lw  = (dec_class == CLS_MEM) && (opcode[3:0] == OP_LW);
    assign is_jmp = (dec_class == CLS_BRANCH) && (opcode[3:0] == OP_JMP);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_q;
    logic       mem_err_q;

    assign mem_timeout = (state_q == ST_MEM) && (wait_q == 4'(TIMEOUT_CYCLES));

    // Counter is held at zero outside MEM, so it starts clean on every MEM entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_q != ST_MEM)
                wait_q <= '0;
            else if (!mem_ready && !mem_timeout)
                wait_q <= wait_q + 4'd1;
            if (mem_timeout)
                mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_timeout = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ir_load     = 1'b0;
        alu_ctl     = ALU_NONE;
        acc_ctl     = ACC_NONE;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_load = instr_valid;
                if (instr_valid)
                    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    set_illegal = 1'b1;
                    pc_inc      = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctl = dec_alu;
                acc_ctl = dec_acc;
                case (dec_class)
                    CLS_ALU: state_d = ST_WB;
                    CLS_MEM: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_load = is_jmp;
                        pc_inc  = !is_jmp;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                alu_ctl = dec_alu;
                acc_ctl = dec_acc;
                if (mem_timeout) begin
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    mem_re = is_lw;
                    mem_we = !is_lw;
                    if (mem_ready) begin
                        if (is_lw) begin
                            state_d = ST_WB;
                        end else begin
                            pc_inc  = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_WB: begin
                alu_ctl = dec_alu;
                acc_ctl = dec_acc;
                reg_we  = 1'b1;
                pc_inc  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl; a CNT_W=2 twin exercises counter wrap.
module tb_multicycle_ctrl;

    localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011, A_SH  = 3'b100, A_N   = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;

    logic        ir_load, reg_we, mem_re, mem_we, pc_inc, pc_load, illegal, mem_err;
    logic [2:0]  alu_ctl, state_o;
    logic [1:0]  acc_ctl;
    logic [15:0] retired;

    logic        s_ir_load, s_reg_we, s_mem_re, s_mem_we, s_pc_inc, s_pc_load, s_illegal, s_mem_err;
    logic [2:0]  s_alu_ctl, s_state_o;
    logic [1:0]  s_acc_ctl;
    logic [1:0]  s_retired;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir;
        logic [2:0]  alu;
        logic [1:0]  acc;
        logic        rwe, re, we, inc, ld, ill;
        logic [15:0] ret;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] op;
        logic       iv;
        logic       mr;
        exp_t       exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_ret;
    logic        exp_ill;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid), .mem_ready(mem_ready),
        .ir_load(ir_load), .alu_ctl(alu_ctl), .acc_ctl(acc_ctl), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .pc_inc(pc_inc), .pc_load(pc_load),
        .illegal(illegal), .mem_err(mem_err), .retired(retired), .state_o(state_o)
    );

    multicycle_ctrl #(.CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid), .mem_ready(mem_ready),
        .ir_load(s_ir_load), .alu_ctl(s_alu_ctl), .acc_ctl(s_acc_ctl), .reg_we(s_reg_we),
        .mem_re(s_mem_re), .mem_we(s_mem_we), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
        .illegal(s_illegal), .mem_err(s_mem_err), .retired(s_retired), .state_o(s_state_o)
    );

    task automatic add(input logic r, input logic [3:0] op, input logic iv, input logic mr,
                       input logic [2:0] st, input logic ir, input logic [2:0] alu,
                       input logic [1:0] acc, input logic rwe, input logic re, input logic we,
                       input logic inc, input logic ld);
        vec_t v;
        v.rst = r;
        v.op  = op;
        v.iv  = iv;
        v.mr  = mr;
        v.exp = '{st, ir, alu, acc, rwe, re, we, inc, ld, exp_ill, exp_ret};
        vecs.push_back(v);
    endtask

    // Four-cycle register-register instruction: FETCH, DECODE, EXEC, WB.
    task automatic alu_instr(input logic [3:0] op, input logic [2:0] alu, input logic [1:0] acc);
        add(0, op, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, op, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, op, 0, 0, 3'd2, 0, alu, acc,   0, 0, 0, 0, 0);
        add(0, op, 0, 0, 3'd4, 0, alu, acc,   1, 0, 0, 1, 0);
        exp_ret = exp_ret + 16'd1;
    endtask

    task automatic cyc(input logic r, input logic [3:0] op, input logic iv, input logic mr);
        @(posedge clk);
        #1;
        rst = r;
        opcode = op;
        instr_valid = iv;
        mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t got;
        exp_ret = 16'd0;
        exp_ill = 1'b0;

        // add: 0,1,2,4 then FETCH; mem_ready in DECODE must be ignored
        add(0, 4'd0, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd0, 0, 1, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd0, 0, 0, 3'd2, 0, A_ADD, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd0, 0, 0, 3'd4, 0, A_ADD, 2'b00, 1, 0, 0, 1, 0);
        exp_ret = 16'd1;
        // lw with three stall cycles
        add(0, 4'd7, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd7, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd7, 0, 1, 3'd2, 0, A_ADD, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 4'd7, 0, 0, 3'd3, 0, A_ADD, 2'b00, 0, 1, 0, 0, 0);
        add(0, 4'd7, 0, 1, 3'd3, 0, A_ADD, 2'b00, 0, 1, 0, 0, 0);
        add(0, 4'd7, 0, 0, 3'd4, 0, A_ADD, 2'b00, 1, 0, 0, 1, 0);
        exp_ret = 16'd2;
        // sw, immediate ready
        add(0, 4'd8, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd8, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd8, 0, 0, 3'd2, 0, A_ADD, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd8, 0, 1, 3'd3, 0, A_ADD, 2'b00, 0, 0, 1, 1, 0);
        exp_ret = 16'd3;
        // jmp with instr_valid held high outside FETCH
        add(0, 4'd9, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd9, 1, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd9, 1, 0, 3'd2, 0, A_N, 2'b00, 0, 0, 0, 0, 1);
        exp_ret = 16'd4;
        // ban, preceded by two idle FETCH cycles
        add(0, 4'd10, 0, 0, 3'd0, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd10, 0, 1, 3'd0, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd10, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd10, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd10, 0, 0, 3'd2, 0, A_SUB, 2'b00, 0, 0, 0, 1, 0);
        exp_ret = 16'd5;
        alu_instr(4'd2, A_SUB, 2'b00);
        alu_instr(4'd3, A_AND, 2'b00);
        alu_instr(4'd4, A_OR,  2'b00);
        alu_instr(4'd5, A_SH,  2'b01);
        alu_instr(4'd6, A_SH,  2'b10);
        alu_instr(4'd1, A_ADD, 2'b00);
        // illegal opcode 1100: pc_inc in DECODE, sticky flag afterwards, no retire
        add(0, 4'd12, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd12, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 1, 0);
        exp_ill = 1'b1;
        alu_instr(4'd0, A_ADD, 2'b00);
        // reset in the middle of a lw MEM wait
        add(0, 4'd7, 1, 0, 3'd0, 1, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd7, 0, 0, 3'd1, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd7, 0, 0, 3'd2, 0, A_ADD, 2'b00, 0, 0, 0, 0, 0);
        add(0, 4'd7, 0, 0, 3'd3, 0, A_ADD, 2'b00, 0, 1, 0, 0, 0);
        add(1, 4'd7, 0, 0, 3'd3, 0, A_ADD, 2'b00, 0, 1, 0, 0, 0);
        exp_ret = 16'd0;
        exp_ill = 1'b0;
        for (int i = 0; i < 5; i++)
            add(0, 4'd7, 0, 0, 3'd0, 0, A_N, 2'b00, 0, 0, 0, 0, 0);
        alu_instr(4'd0, A_ADD, 2'b00);
        alu_instr(4'd0, A_ADD, 2'b00);
        alu_instr(4'd0, A_ADD, 2'b00);
        alu_instr(4'd0, A_ADD, 2'b00);
        alu_instr(4'd0, A_ADD, 2'b00);

        rst = 1'b1;
        @(posedge clk);
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].op, vecs[i].iv, vecs[i].mr);
            got = '{state_o, ir_load, alu_ctl, acc_ctl, reg_we, mem_re, mem_we, pc_inc, pc_load,
                    illegal, retired};
            tests++;
            if (got !== vecs[i].exp) begin
                fails++;
                $display("FAIL vec%0d outputs: got st=%0d ir=%b alu=%b acc=%b rwe=%b re=%b we=%b inc=%b ld=%b ill=%b ret=%0d, expected st=%0d ir=%b alu=%b acc=%b rwe=%b re=%b we=%b inc=%b ld=%b ill=%b ret=%0d",
                         i, got.st, got.ir, got.alu, got.acc, got.rwe, got.re, got.we, got.inc,
                         got.ld, got.ill, got.ret, vecs[i].exp.st, vecs[i].exp.ir,
                         vecs[i].exp.alu, vecs[i].exp.acc, vecs[i].exp.rwe, vecs[i].exp.re,
                         vecs[i].exp.we, vecs[i].exp.inc, vecs[i].exp.ld, vecs[i].exp.ill,
                         vecs[i].exp.ret);
            end else begin
                $display("[TB] vec %0d op=%0d st=%0d ret=%0d ok", i, vecs[i].op, state_o, retired);
            end
            chk($sformatf("vec%0d pc_excl", i), {30'd0, pc_inc, pc_load},
                {30'd0, pc_inc & ~pc_load, pc_load & ~pc_inc});
            chk($sformatf("vec%0d mem_err", i), {31'd0, mem_err}, 32'd0);
            chk($sformatf("vec%0d wrap_retired", i), {30'd0, s_retired},
                {30'd0, vecs[i].exp.ret[1:0]});
        end

        // sw with a long RAM stall
        cyc(0, 4'd8, 1, 0);
        chk("sw_fetch", {29'd0, state_o}, 32'd0);
        cyc(0, 4'd8, 0, 0);
        cyc(0, 4'd8, 0, 0);
        chk("sw_exec", {29'd0, state_o}, 32'd2);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            cyc(0, 4'd8, 0, 0);
            chk($sformatf("to_wait%0d", i), {26'd0, state_o, mem_we, mem_err, pc_inc},
                {26'd0, 3'd3, 1'b1, 1'b0, 1'b0});
        end
        cyc(0, 4'd8, 0, 0);
        chk("to_expire", {25'd0, state_o, mem_we, mem_re, pc_inc, reg_we},
            {25'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0});
        cyc(0, 4'd8, 0, 0);
        chk("to_after", {12'd0, state_o, mem_err, retired}, {12'd0, 3'd0, 1'b1, exp_ret});
`else
        for (int i = 0; i < 20; i++) begin
            cyc(0, 4'd8, 0, 0);
            chk($sformatf("stall%0d", i), {26'd0, state_o, mem_we, mem_err, pc_inc},
                {26'd0, 3'd3, 1'b1, 1'b0, 1'b0});
        end
        cyc(0, 4'd8, 0, 1);
        chk("stall_done", {27'd0, state_o, mem_we, pc_inc}, {27'd0, 3'd3, 1'b1, 1'b1});
        exp_ret = exp_ret + 16'd1;
        cyc(0, 4'd8, 0, 0);
        chk("stall_retire", {13'd0, state_o, retired}, {13'd0, 3'd0, exp_ret});
        chk("stall_wrap", {30'd0, s_retired}, {30'd0, exp_ret[1:0]});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
